vga_patt_sequencer: RTL and testbench
=====================================

// Module: vga_patt_sequencer
// PURPOSE
//  Selects which test pattern drives the VGA driver's 3-bit rgb input, and when.
//  Sits between genPatt/vgaDriver: takes row/column from the driver, muxes external pattern + 3 internal patterns.
//  Pattern changes happen only at end-of-frame (tear-free); auto-cycle or manual step via next_i pulse.
// PARAMETERS
//  LAST_ROW     479  row index of last visible line (row_i is 9 bits)
//  LAST_COL     639  column index of last visible pixel (column_i is 10 bits)
//  HOLD_FRAMES  120  frames each pattern is shown in AUTO mode (>=1)
//  FCNT_W       8    width of frame counter; must hold HOLD_FRAMES-1
// PORTS
//  clk_i        in   1       system clock, 50 MHz
//  reset_ni     in   1       asynchronous reset, active low
//  row_i        in   9       current pixel row from vgaDriver
//  column_i     in   10      current pixel column from vgaDriver
//  rgb_ext_i    in   3       external pattern {R,G,B} from genPatt
//  auto_i       in   1       1 = AUTO cycling, 0 = MANUAL (level, sampled each clock)
//  next_i       in   1       single-cycle step request (debounced upstream)
//  rgb_o        out  3       selected pixel colour {R,G,B} to vgaDriver
//  patt_sel_o   out  2       active pattern index
//  frame_cnt_o  out  FCNT_W  frames shown of the current pattern
//  eof_o        out  1       1-cycle pulse at end of each frame
//  pend_o       out  1       step request accepted, waiting for end of frame
// BEHAVIOUR
//  Interface: one clock clk_i; reset_ni asynchronous, active low. All flops reset on reset_ni=0.
//  Reset values: patt_sel_o=0, frame_cnt_o=0, eof_o=0, pend_o=0, colour reg=3'b001, state=AUTO.
//  EOF detect: at_end=(row_i==LAST_ROW && column_i==LAST_COL); at_end_q registered.
//   eof_o = registered (at_end && !at_end_q): asserted 1 clock after entry; one pulse per frame even if
//   position holds at end for many clocks. No pulse while position stays at end after reset release.
//  Patterns (rgb_o combinational from patt_sel_o, row_i, column_i; no added latency):
//   0: rgb_ext_i passthrough   1: solid colour reg   2: bars rgb=column_i[9:7] (column>=640 -> 3'b000)
//   3: checker rgb = (row_i[5]^column_i[5]) ? 3'b111 : 3'b000
//  Colour reg: on each eof_o while patt_sel_o==1, increments 1..7, wraps 7->1 (black never shown).
//  FSM (2 bits): AUTO, MANUAL, PEND.
//   AUTO:   auto_i=0 -> MANUAL (frame_cnt_o keeps value). On eof_o: if frame_cnt_o==HOLD_FRAMES-1
//           then patt_sel_o+=1 (wraps 3->0), frame_cnt_o=0; else frame_cnt_o+=1. next_i ignored.
//   MANUAL: auto_i=1 -> AUTO. next_i=1 -> PEND, pend_o=1. eof_o increments frame_cnt_o (saturates at all-ones).
//   PEND:   on eof_o: patt_sel_o+=1, frame_cnt_o=0, pend_o=0 -> MANUAL (or AUTO if auto_i=1).
//           Further next_i pulses while PEND are dropped (max one step per frame).
//           auto_i=1 without eof: stay PEND; step still taken at next eof.
//  Simultaneous next_i and eof_o in MANUAL: request goes to PEND; step is taken at the following eof.
//  patt_sel_o/frame_cnt_o update on the edge where eof_o=1 -> visible from the next clock, long before (0,0).
//  Reset mid-frame: outputs return to reset values asynchronously; pattern 0 shown immediately.
// CONFIGURATION
//  SEQ_BORDER_EN defined: rgb_o forced to 3'b111 when row_i in {0,LAST_ROW} or column_i in {0,LAST_COL},
//   overriding all patterns (frame-alignment aid for monitor tuning).
//  SEQ_BORDER_EN undefined: no override; border pixels follow the selected pattern.
// TESTING
//  1 reset_ni=0 mid-operation -> patt_sel_o=0, frame_cnt_o=0, pend_o=0, rgb_o==rgb_ext_i at once.
//  2 AUTO, HOLD_FRAMES=3, 13 frames -> sel 0,0,0,1,1,1,2,2,2,3,3,3,0; exactly one eof_o per frame.
//  3 MANUAL, next_i at row 100 -> pend_o=1, sel unchanged until eof, then sel+1, pend_o=0.
//  4 MANUAL, 3 next_i pulses in one frame -> exactly one step; next_i on the eof_o cycle -> step next frame.
//  5 sel=1, 8 frames -> rgb_o 1,2,3,4,5,6,7,1; sel=3 at (row 32,col 0) -> 3'b111, (0,0) -> 3'b000.
//  6 SEQ_BORDER_EN: (0,320),(479,5),(240,639) -> 3'b111 in all patterns; without it, pattern colour.

Source files
------------

// File: rtl/vga_patt_sequencer_if.sv
// Pixel/pattern bus between the VGA driver side and vga_patt_sequencer.
// The driver side (master) supplies position, external pattern and controls; the sequencer (slave) returns colour and status.
interface vga_patt_sequencer_if #(
  parameter int FCNT_W = 8
);
  logic [8:0]        row_i;
  logic [9:0]        column_i;
  logic [2:0]        rgb_ext_i;
  logic              auto_i;
  logic              next_i;
  logic [2:0]        rgb_o;
  logic [1:0]        patt_sel_o;
  logic [FCNT_W-1:0] frame_cnt_o;
  logic              eof_o;
  logic              pend_o;

  modport master (
    output row_i, column_i, rgb_ext_i, auto_i, next_i,
    input  rgb_o, patt_sel_o, frame_cnt_o, eof_o, pend_o
  );

  modport slave (
    input  row_i, column_i, rgb_ext_i, auto_i, next_i,
    output rgb_o, patt_sel_o, frame_cnt_o, eof_o, pend_o
  );
endinterface

// File: rtl/vga_patt_sequencer.sv
// Test-pattern sequencer: picks one of four patterns for the VGA rgb input and switches only at end of frame.
// Optional feature: define SEQ_BORDER_EN to force a white border on the first/last visible row and column.
module vga_patt_sequencer #(
  parameter int LAST_ROW    = 479,
  parameter int LAST_COL    = 639,
  parameter int HOLD_FRAMES = 120,
  parameter int FCNT_W      = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  vga_patt_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_AUTO   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_PEND   = 2'd2
  } state_t;

  localparam logic [8:0]        LAST_ROW_V = 9'(LAST_ROW);
  localparam logic [9:0]        LAST_COL_V = 10'(LAST_COL);
  localparam logic [FCNT_W-1:0] HOLD_LAST  = FCNT_W'(HOLD_FRAMES - 1);
  localparam logic [FCNT_W-1:0] CNT_ONE    = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] CNT_MAX    = '1;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]        colour_q, colour_d;
  logic              at_end, at_end_q, eof_q;
  logic [2:0]        rgb_patt;

  // ---------------------------------------------------------------------------
  // End-of-frame detection
  // ---------------------------------------------------------------------------
  assign at_end = (bus.row_i == LAST_ROW_V) && (bus.column_i == LAST_COL_V);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: at_end_q resets to 1 so a position parked at the end across reset release is not a new frame end.
      at_end_q <= 1'b1;
      eof_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      at_end_q <= at_end;
      eof_q    <= at_end && !at_end_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_AUTO;
      sel_q    <= 2'd0;
      cnt_q    <= '0;
      colour_q <= 3'd1;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      colour_q <= colour_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next state, pattern index and frame counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_AUTO: begin
        if (eof_q) begin
          if (cnt_q == HOLD_LAST) begin
            sel_d = sel_q + 2'd1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        if (!bus.auto_i) state_d = ST_MANUAL;
      end

      ST_MANUAL: begin
        if (eof_q && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
        // A request coinciding with eof waits for the following frame end.
        if (bus.auto_i)      state_d = ST_AUTO;
        else if (bus.next_i) state_d = ST_PEND;
      end

      ST_PEND: begin
        if (eof_q) begin
          sel_d   = sel_q + 2'd1;
          cnt_d   = '0;
          state_d = bus.auto_i ? ST_AUTO : ST_MANUAL;
        end
      end

      default: state_d = ST_AUTO;
    endcase
  end

  // Solid colour walks 1..7 once per frame while it is on screen; black is skipped.
  always_comb begin
    colour_d = colour_q;
    if (eof_q && (sel_q == 2'd1)) colour_d = (colour_q == 3'd7) ? 3'd1 : colour_q + 3'd1;
  end

  // ---------------------------------------------------------------------------
  // Pattern mux (combinational, same cycle as row/column)
  // ---------------------------------------------------------------------------
  always_comb begin
    rgb_patt = 3'b000;
    unique case (sel_q)
      2'd0: rgb_patt = bus.rgb_ext_i;
      2'd1: rgb_patt = colour_q;
      2'd2: rgb_patt = (bus.column_i > LAST_COL_V) ? 3'b000 : bus.column_i[9:7];
      2'd3: rgb_patt = (bus.row_i[5] ^ bus.column_i[5]) ? 3'b111 : 3'b000;
      default: rgb_patt = 3'b000;
    endcase
  end

`ifdef SEQ_BORDER_EN
  logic on_border;
  assign on_border = (bus.row_i == 9'd0) || (bus.row_i == LAST_ROW_V) ||
                     (bus.column_i == 10'd0) || (bus.column_i == LAST_COL_V);
  assign bus.rgb_o = on_border ? 3'b111 : rgb_patt;
`else
  assign bus.rgb_o = rgb_patt;
`endif

  assign bus.patt_sel_o  = sel_q;
  assign bus.frame_cnt_o = cnt_q;
  assign bus.eof_o       = eof_q;
  assign bus.pend_o      = (state_q == ST_PEND);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_eof_single_cycle : assert property (@(posedge clk_i) disable iff (!reset_ni)
    eof_q |=> !eof_q);

  a_pend_holds_sel : assert property (@(posedge clk_i) disable iff (!reset_ni)
    (state_q == ST_PEND && !eof_q) |=> $stable(sel_q));

  a_colour_not_black : assert property (@(posedge clk_i) disable iff (!reset_ni)
    colour_q != 3'd0);

endmodule

// File: tb/tb_vga_patt_sequencer.sv
// Self-checking bench for vga_patt_sequencer: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vga_patt_sequencer;

  localparam int HOLD = 3;
  localparam int LR   = 479;
  localparam int LC   = 639;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_patt_sequencer_if #(.FCNT_W(8)) bus ();

  vga_patt_sequencer #(
    .LAST_ROW   (LR),
    .LAST_COL   (LC),
    .HOLD_FRAMES(HOLD),
    .FCNT_W     (8)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int eof_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: frame-level bookkeeping of pattern, hold count, colour, mode
  // ---------------------------------------------------------------------------
  int m_sel = 0, m_cnt = 0, m_colour = 1;
  bit m_manual = 0, m_pend = 0, m_eof = 0, m_prev_end = 1;

  function automatic bit pos_at_end();
    return (int'(bus.row_i) == LR) && (int'(bus.column_i) == LC);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 0; m_cnt <= 0; m_colour <= 1;
      m_manual <= 0; m_pend <= 0; m_eof <= 0; m_prev_end <= 1;
    end else begin
      m_eof      <= pos_at_end() && !m_prev_end;
      m_prev_end <= pos_at_end();
      if (m_eof && m_sel == 1) m_colour <= (m_colour % 7) + 1;
      if (m_pend) begin
        if (m_eof) begin
          m_sel <= (m_sel + 1) % 4; m_cnt <= 0; m_pend <= 0; m_manual <= !bus.auto_i;
        end
      end else if (!m_manual) begin
        if (m_eof) begin
          if (m_cnt + 1 == HOLD) begin m_sel <= (m_sel + 1) % 4; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        m_manual <= !bus.auto_i;
      end else begin
        if (m_eof) m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
        if (bus.auto_i) m_manual <= 0;
        else if (bus.next_i) m_pend <= 1;
      end
    end
  end

  function automatic int exp_rgb();
    int r = int'(bus.row_i);
    int c = int'(bus.column_i);
    int v;
    case (m_sel)
      0:       v = int'(bus.rgb_ext_i);
      1:       v = m_colour;
      2:       v = (c > LC) ? 0 : c / 128;
      default: v = (((r / 32) % 2) != ((c / 32) % 2)) ? 7 : 0;
    endcase
`ifdef SEQ_BORDER_EN
    if (r == 0 || r == LR || c == 0 || c == LC) v = 7;
`endif
    return v;
  endfunction

  // Compare process: outputs against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    check("rgb",       bus.rgb_o,       exp_rgb());
    check("patt_sel",  bus.patt_sel_o,  m_sel);
    check("frame_cnt", bus.frame_cnt_o, m_cnt);
    check("eof",       bus.eof_o,       m_eof);
    check("pend",      bus.pend_o,      m_pend);
    if (bus.eof_o) eof_seen++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int r, input int c);
    bus.row_i    = 9'(r);
    bus.column_i = 10'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit next_on_eof);
    eof_seen = 0;
    tick(200, 300);
    tick(LR, LC);
    bus.next_i = next_on_eof;
    tick(LR, LC);
    bus.next_i = 1'b0;
    tick(0, 0);
    check("eof_per_frame", eof_seen, 1);
  endtask

  task automatic step_request(input int r);
    bus.next_i = 1'b1;
    tick(r, 20);
    bus.next_i = 1'b0;
  endtask

  task automatic border_checks(input int e0, input int e1, input int e2);
`ifdef SEQ_BORDER_EN
    tick(0, 320);   check("border_top",   bus.rgb_o, 7);
    tick(LR, 5);    check("border_bot",   bus.rgb_o, 7);
    tick(240, LC);  check("border_right", bus.rgb_o, 7);
`else
    tick(0, 320);   check("border_top",   bus.rgb_o, e0);
    tick(LR, 5);    check("border_bot",   bus.rgb_o, e1);
    tick(240, LC);  check("border_right", bus.rgb_o, e2);
`endif
  endtask

  int t2_exp[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int t5_exp[8]  = '{1, 2, 3, 4, 5, 6, 7, 1};

  initial begin
    bus.row_i = 9'(LR); bus.column_i = 10'(LC);
    bus.rgb_ext_i = 3'b010; bus.auto_i = 1'b1; bus.next_i = 1'b0;

    // Position parked at frame end across reset release: no pulse.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    eof_seen = 0;
    tick(LR, LC); tick(LR, LC); tick(LR, LC);
    check("no_eof_after_reset", eof_seen, 0);
    tick(0, 0);

    // AUTO cycling with HOLD=3 over 13 frames.
    for (int k = 0; k < 13; k++) begin
      tick(10, 10);
      check("auto_sel", bus.patt_sel_o, t2_exp[k]);
      run_frame(1'b0);
    end

    // MANUAL: request at row 100 waits for end of frame.
    bus.auto_i = 1'b0;
    tick(50, 50);
    step_request(100);
    check("pend_set", bus.pend_o, 1);
    check("sel_held", bus.patt_sel_o, 0);
    tick(200, 200);
    check("sel_held2", bus.patt_sel_o, 0);
    run_frame(1'b0);
    check("manual_step", bus.patt_sel_o, 1);
    check("pend_clr", bus.pend_o, 0);

    // Three requests in one frame give one step; a request on the eof cycle waits a frame.
    for (int i = 0; i < 3; i++) begin
      step_request(60 + i);
      tick(70, 10);
    end
    run_frame(1'b0);
    check("one_step", bus.patt_sel_o, 2);
    run_frame(1'b0);
    check("no_step", bus.patt_sel_o, 2);
    run_frame(1'b1);
    check("eof_req_sel", bus.patt_sel_o, 2);
    check("eof_req_pend", bus.pend_o, 1);
    run_frame(1'b0);
    check("eof_req_step", bus.patt_sel_o, 3);

    // Fresh start, then solid colour over 8 frames.
    #1 rst_n = 1'b0;
    tick(0, 0);
    #1 rst_n = 1'b1;
    tick(0, 0);
    step_request(30);
    run_frame(1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(10, 10);
      check("solid_colour", bus.rgb_o, t5_exp[k]);
      run_frame(1'b0);
    end

    // Bars, then checker, then external with border pixels.
    step_request(30);
    run_frame(1'b0);
    check("sel_bars", bus.patt_sel_o, 2);
    border_checks(2, 0, 4);
    step_request(30);
    run_frame(1'b0);
    check("sel_checker", bus.patt_sel_o, 3);
    tick(32, 0);
    check("checker_32_0", bus.rgb_o, 7);
    tick(0, 0);
`ifdef SEQ_BORDER_EN
    check("checker_0_0", bus.rgb_o, 7);
`else
    check("checker_0_0", bus.rgb_o, 0);
`endif
    border_checks(0, 0, 0);
    step_request(30);
    run_frame(1'b0);
    border_checks(2, 2, 2);

    // Reset mid-operation with a request pending.
    step_request(30);
    run_frame(1'b0);
    run_frame(1'b0);
    check("pre_reset_cnt", bus.frame_cnt_o, 1);
    step_request(100);
    check("pre_reset_pend", bus.pend_o, 1);
    bus.rgb_ext_i = 3'b101;
    rst_n = 1'b0;
    #1;
    check("rst_sel", bus.patt_sel_o, 0);
    check("rst_cnt", bus.frame_cnt_o, 0);
    check("rst_pend", bus.pend_o, 0);
    check("rst_eof", bus.eof_o, 0);
    check("rst_rgb", bus.rgb_o, 5);
    tick(100, 100);
    #1 rst_n = 1'b1;
    tick(100, 101);
    tick(100, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
